// File: rtl/multicycle_control_unit_pkg.sv
// Shared definitions for the multicycle RV32I control path: FSM states,
// base opcodes and the ALU operation codes also used by the datapath.
package multicycle_control_unit_pkg;

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        MEM       = 3'd3,
        WRITEBACK = 3'd4,
        TRAP      = 3'd5
    } state_t;

    localparam int ALU_CODE_W = 5;
    typedef logic [ALU_CODE_W-1:0] alu_code_t;

    localparam alu_code_t ALU_NOP   = 5'd0;
    localparam alu_code_t ALU_ADD   = 5'd1;
    localparam alu_code_t ALU_SUB   = 5'd2;
    localparam alu_code_t ALU_SLL   = 5'd3;
    localparam alu_code_t ALU_SLT   = 5'd4;
    localparam alu_code_t ALU_SLTU  = 5'd5;
    localparam alu_code_t ALU_XOR   = 5'd6;
    localparam alu_code_t ALU_SRL   = 5'd7;
    localparam alu_code_t ALU_SRA   = 5'd8;
    localparam alu_code_t ALU_OR    = 5'd9;
    localparam alu_code_t ALU_AND   = 5'd10;
    localparam alu_code_t ALU_PASSB = 5'd11;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    function automatic logic is_legal_opcode(input logic [6:0] op);
        case (op)
            OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: return 1'b1;
            default:                           return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_unit_alu_decoder.sv
// Single-cycle RV32I opcode/funct decode to ALU operation and operand selects.
module alu_decoder
    import multicycle_control_unit_pkg::*;
#(
    parameter int ALUCTRL_W = 5
) (
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic                 funct7_5,
    output logic [ALUCTRL_W-1:0] alu_ctrl,
    output logic                 alu_src_a,
    output logic                 alu_src_b
);

    alu_code_t code;

    function automatic alu_code_t arith_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    always_comb begin
        code      = ALU_NOP;
        alu_src_a = 1'b0;
        alu_src_b = 1'b0;
        case (opcode)
            OP_R: code = arith_op(funct3, funct7_5);
            OP_IMM: begin
                // bit 30 is immediate data except for the right-shift encodings
                code      = arith_op(funct3, (funct3 == 3'b101) && funct7_5);
                alu_src_b = 1'b1;
            end
            OP_LOAD, OP_STORE, OP_JALR: begin
                code      = ALU_ADD;
                alu_src_b = 1'b1;
            end
            OP_BRANCH: begin
                case (funct3)
                    3'b100, 3'b101: code = ALU_SLT;
                    3'b110, 3'b111: code = ALU_SLTU;
                    default:        code = ALU_SUB;
                endcase
            end
            OP_LUI: begin
                code      = ALU_PASSB;
                alu_src_b = 1'b1;
            end
            OP_AUIPC, OP_JAL: begin
                code      = ALU_ADD;
                alu_src_a = 1'b1;
                alu_src_b = 1'b1;
            end
            default: code = ALU_NOP;
        endcase
    end

    assign alu_ctrl = ALUCTRL_W'(code);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control FSM: fetch/decode/execute/mem/writeback with a
// memory wait-timeout and an absorbing trap state.
module multicycle_control_unit
    import multicycle_control_unit_pkg::*;
#(
    parameter int ALUCTRL_W   = 5,
    parameter int MAX_WAIT    = 16,
    parameter bit ENABLE_TRAP = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          instruction_code,
    input  logic                 branch_taken,
    input  logic                 mem_ready,
    output logic                 InstrRead,
    output logic                 IRWrite,
    output logic                 PCWrite,
    output logic                 ALUSrc_A,
    output logic                 ALUSrc_B,
    output logic [1:0]           MemtoReg,
    output logic                 RegWrite,
    output logic                 MemRead,
    output logic                 MemWrite,
    output logic                 Branch,
    output logic [1:0]           PCSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic                 instr_retired,
    output logic                 illegal_instr,
    output logic                 bus_error,
    output logic [2:0]           state_o
);

    localparam int CNT_W = $clog2(MAX_WAIT + 2);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

    state_t state, state_next;

    logic [6:0] opcode;
    logic       legal, is_load, is_store, is_branch, is_jal, is_jalr, is_lui;
    logic       waiting, timeout;
    logic [CNT_W-1:0] wait_cnt;
    logic       illegal_q, bus_err_q;

    logic [ALUCTRL_W-1:0] dec_alu;
    logic                 dec_src_a, dec_src_b;
    logic                 unused_instr_bits;

    assign opcode    = instruction_code[6:0];
    assign legal     = is_legal_opcode(opcode);
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_branch = (opcode == OP_BRANCH);
    assign is_jal    = (opcode == OP_JAL);
    assign is_jalr   = (opcode == OP_JALR);
    assign is_lui    = (opcode == OP_LUI);

    assign unused_instr_bits = ^{instruction_code[31], instruction_code[29:15],
                                 instruction_code[11:7]};

    alu_decoder #(
        .ALUCTRL_W(ALUCTRL_W)
    ) u_alu_decoder (
        .opcode   (opcode),
        .funct3   (instruction_code[14:12]),
        .funct7_5 (instruction_code[30]),
        .alu_ctrl (dec_alu),
        .alu_src_a(dec_src_a),
        .alu_src_b(dec_src_b)
    );

    // Expiry only on a not-ready cycle, so a late mem_ready still completes
    assign waiting = (state == FETCH) || (state == MEM);
    assign timeout = (MAX_WAIT != 0) && waiting && !mem_ready && (wait_cnt == WAIT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Counter is zero outside FETCH/MEM, so entry into either starts from zero
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt  <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            if (waiting && !mem_ready && !timeout && (MAX_WAIT != 0)) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end else begin
                wait_cnt <= '0;
            end
            if ((state == DECODE) && !legal && ENABLE_TRAP) begin
                illegal_q <= 1'b1;
            end
            if (timeout) begin
                bus_err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            FETCH: begin
                if (timeout)        state_next = TRAP;
                else if (mem_ready) state_next = DECODE;
            end
            DECODE: begin
                if (legal)            state_next = EXECUTE;
                else if (ENABLE_TRAP) state_next = TRAP;
                else                  state_next = FETCH;
            end
            EXECUTE: begin
                if (is_branch)                state_next = FETCH;
                else if (is_load || is_store) state_next = MEM;
                else                          state_next = WRITEBACK;
            end
            MEM: begin
                if (timeout)        state_next = TRAP;
                else if (mem_ready) state_next = is_load ? WRITEBACK : FETCH;
            end
            WRITEBACK: state_next = FETCH;
            TRAP:      state_next = TRAP;
            default:   state_next = FETCH;
        endcase
    end

    always_comb begin
        InstrRead     = 1'b0;
        IRWrite       = 1'b0;
        PCWrite       = 1'b0;
        ALUSrc_A      = 1'b0;
        ALUSrc_B      = 1'b0;
        MemtoReg      = 2'd0;
        RegWrite      = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        Branch        = 1'b0;
        PCSrc         = 2'd0;
        ALUControl    = ALUCTRL_W'(ALU_NOP);
        instr_retired = 1'b0;
        illegal_instr = 1'b0;
        bus_error     = 1'b0;
        state_o       = 3'd0;
        if (rst_n) begin
            illegal_instr = illegal_q;
            bus_error     = bus_err_q;
            state_o       = state;
            case (state)
                FETCH: begin
                    InstrRead = 1'b1;
                    IRWrite   = mem_ready;
                end
                DECODE: begin
                    if (!legal && !ENABLE_TRAP) begin
                        PCWrite       = 1'b1;
                        instr_retired = 1'b1;
                    end
                end
                EXECUTE: begin
                    ALUControl = dec_alu;
                    ALUSrc_A   = dec_src_a;
                    ALUSrc_B   = dec_src_b;
                    if (is_branch) begin
                        Branch        = 1'b1;
                        PCWrite       = 1'b1;
                        PCSrc         = branch_taken ? 2'd1 : 2'd0;
                        instr_retired = 1'b1;
                    end
                end
                MEM: begin
                    ALUControl = dec_alu;
                    ALUSrc_A   = dec_src_a;
                    ALUSrc_B   = dec_src_b;
                    MemRead    = is_load;
                    MemWrite   = is_store;
                    if (is_store && mem_ready) begin
                        PCWrite       = 1'b1;
                        instr_retired = 1'b1;
                    end
                end
                WRITEBACK: begin
                    ALUControl    = dec_alu;
                    ALUSrc_A      = dec_src_a;
                    ALUSrc_B      = dec_src_b;
                    RegWrite      = 1'b1;
                    PCWrite       = 1'b1;
                    instr_retired = 1'b1;
                    if (is_load)                 MemtoReg = 2'd1;
                    else if (is_jal || is_jalr)  MemtoReg = 2'd2;
                    else if (is_lui)             MemtoReg = 2'd3;
                    if (is_jal)       PCSrc = 2'd2;
                    else if (is_jalr) PCSrc = 2'd3;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed, table-driven bench for multicycle_control_unit plus hand-written
// sequences for trap, timeout and mid-access reset.
module tb_multicycle_control_unit;
    import multicycle_control_unit_pkg::*;

    logic        clk, rst_n;
    logic [31:0] instruction_code;
    logic        branch_taken, mem_ready;

    logic       InstrRead, IRWrite, PCWrite, ALUSrc_A, ALUSrc_B, RegWrite;
    logic       MemRead, MemWrite, Branch, instr_retired, illegal_instr, bus_error;
    logic [1:0] MemtoReg, PCSrc;
    logic [4:0] ALUControl;
    logic [2:0] state_o;

    logic       nt_InstrRead, nt_IRWrite, nt_PCWrite, nt_ALUSrc_A, nt_ALUSrc_B, nt_RegWrite;
    logic       nt_MemRead, nt_MemWrite, nt_Branch, nt_instr_retired, nt_illegal_instr, nt_bus_error;
    logic [1:0] nt_MemtoReg, nt_PCSrc;
    logic [4:0] nt_ALUControl;
    logic [2:0] nt_state_o;

    multicycle_control_unit #(
        .ALUCTRL_W(5), .MAX_WAIT(4), .ENABLE_TRAP(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .instruction_code(instruction_code),
        .branch_taken(branch_taken), .mem_ready(mem_ready),
        .InstrRead(InstrRead), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .ALUSrc_A(ALUSrc_A), .ALUSrc_B(ALUSrc_B), .MemtoReg(MemtoReg),
        .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .Branch(Branch), .PCSrc(PCSrc), .ALUControl(ALUControl),
        .instr_retired(instr_retired), .illegal_instr(illegal_instr),
        .bus_error(bus_error), .state_o(state_o)
    );

    multicycle_control_unit #(
        .ALUCTRL_W(5), .MAX_WAIT(16), .ENABLE_TRAP(1'b0)
    ) dut_nt (
        .clk(clk), .rst_n(rst_n), .instruction_code(instruction_code),
        .branch_taken(branch_taken), .mem_ready(mem_ready),
        .InstrRead(nt_InstrRead), .IRWrite(nt_IRWrite), .PCWrite(nt_PCWrite),
        .ALUSrc_A(nt_ALUSrc_A), .ALUSrc_B(nt_ALUSrc_B), .MemtoReg(nt_MemtoReg),
        .RegWrite(nt_RegWrite), .MemRead(nt_MemRead), .MemWrite(nt_MemWrite),
        .Branch(nt_Branch), .PCSrc(nt_PCSrc), .ALUControl(nt_ALUControl),
        .instr_retired(nt_instr_retired), .illegal_instr(nt_illegal_instr),
        .bus_error(nt_bus_error), .state_o(nt_state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic        bt;
        int unsigned fwaits;
        int unsigned mwaits;
        int unsigned cycles;
        logic [4:0]  alu;
        logic        src_a;
        logic        src_b;
        int unsigned reg_writes;
        logic [1:0]  m2r;
        logic [1:0]  pcsrc;
        int unsigned mem_rd;
        int unsigned mem_wr;
    } vec_t;

    typedef struct {
        logic        done;
        int unsigned cycles;
        logic [4:0]  alu_exec;
        logic [4:0]  alu_last;
        logic        src_a;
        logic        src_b;
        int unsigned reg_writes;
        logic [1:0]  m2r;
        int unsigned pc_writes;
        logic [1:0]  pcsrc;
        int unsigned mem_rd;
        int unsigned mem_wr;
        int unsigned instr_rd;
        int unsigned ir_wr;
        int unsigned excl_viol;
        int unsigned early_alu;
        int unsigned bus_err;
    } obs_t;

    localparam int NV = 17;
    vec_t vecs[NV];

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " outputs low"},
              {13'd0, InstrRead, IRWrite, PCWrite, ALUSrc_A, ALUSrc_B, MemtoReg, RegWrite,
               MemRead, MemWrite, Branch, PCSrc, instr_retired, illegal_instr, bus_error, state_o},
              32'd0);
        check({tag, " alu nop"}, ALUControl, ALU_NOP);
        check({tag, " nt outputs low"},
              {13'd0, nt_InstrRead, nt_IRWrite, nt_PCWrite, nt_RegWrite, nt_MemRead, nt_MemWrite,
               nt_instr_retired, nt_state_o, nt_ALUControl, nt_PCSrc, nt_MemtoReg},
              32'd0);
    endtask

    // Entered and left at #1 after a rising edge.
    task automatic apply_reset(input string tag);
        @(posedge clk); #1;
        rst_n     = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        check_reset_outputs(tag);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check({tag, " post state"}, state_o, FETCH);
        check({tag, " post InstrRead"}, InstrRead, 1'b1);
        check({tag, " post flags"}, {illegal_instr, bus_error}, 2'b00);
        @(posedge clk); #1;
    endtask

    task automatic run_instr(input vec_t v, output obs_t o);
        int unsigned fw, mw;
        o  = '{default: 0};
        fw = v.fwaits;
        mw = v.mwaits;
        instruction_code = v.instr;
        branch_taken     = v.bt;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            if (state_o == FETCH && fw > 0) begin
                mem_ready = 1'b0;
                fw--;
            end else if (state_o == MEM && mw > 0) begin
                mem_ready = 1'b0;
                mw--;
            end else begin
                mem_ready = 1'b1;
            end
            @(negedge clk);
            if (InstrRead) o.instr_rd++;
            if (IRWrite)   o.ir_wr++;
            if (MemRead)   o.mem_rd++;
            if (MemWrite)  o.mem_wr++;
            if (bus_error) o.bus_err++;
            if (RegWrite) begin
                o.reg_writes++;
                o.m2r = MemtoReg;
            end
            if (PCWrite) begin
                o.pc_writes++;
                o.pcsrc = PCSrc;
            end
            if (state_o == EXECUTE) begin
                o.alu_exec = ALUControl;
                o.src_a    = ALUSrc_A;
                o.src_b    = ALUSrc_B;
            end
            if ((state_o == FETCH || state_o == DECODE) && ALUControl != ALU_NOP) o.early_alu++;
            if ((InstrRead && MemRead) || (InstrRead && MemWrite) || (MemRead && MemWrite))
                o.excl_viol++;
            if (instr_retired) begin
                o.cycles   = cyc;
                o.alu_last = ALUControl;
                o.done     = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (o.done) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t o;
        int unsigned cnt_mw, first_err, cnt_pcw, cnt_ret, cnt_rw, strobes;
        string nm;

        //            instr         bt fw mw cyc alu        sA sB rw m2r pcs mrd mwr
        vecs[0]  = '{32'h002081B3, 0, 0, 0, 4, ALU_ADD,   0, 0, 1, 0, 0, 0, 0};
        vecs[1]  = '{32'h402081B3, 0, 0, 0, 4, ALU_SUB,   0, 0, 1, 0, 0, 0, 0};
        vecs[2]  = '{32'h00500093, 0, 0, 0, 4, ALU_ADD,   0, 1, 1, 0, 0, 0, 0};
        vecs[3]  = '{32'h4020D093, 0, 0, 0, 4, ALU_SRA,   0, 1, 1, 0, 0, 0, 0};
        vecs[4]  = '{32'h0020F1B3, 0, 0, 0, 4, ALU_AND,   0, 0, 1, 0, 0, 0, 0};
        vecs[5]  = '{32'h123452B7, 0, 0, 0, 4, ALU_PASSB, 0, 1, 1, 3, 0, 0, 0};
        vecs[6]  = '{32'h00001297, 0, 0, 0, 4, ALU_ADD,   1, 1, 1, 0, 0, 0, 0};
        vecs[7]  = '{32'h010000EF, 0, 0, 0, 4, ALU_ADD,   1, 1, 1, 2, 2, 0, 0};
        vecs[8]  = '{32'h00008067, 0, 0, 0, 4, ALU_ADD,   0, 1, 1, 2, 3, 0, 0};
        vecs[9]  = '{32'h0000A283, 0, 0, 0, 5, ALU_ADD,   0, 1, 1, 1, 0, 1, 0};
        vecs[10] = '{32'h0000A283, 0, 0, 3, 8, ALU_ADD,   0, 1, 1, 1, 0, 4, 0};
        vecs[11] = '{32'h0050A223, 0, 0, 0, 4, ALU_ADD,   0, 1, 0, 0, 0, 0, 1};
        vecs[12] = '{32'h0050A223, 0, 0, 3, 7, ALU_ADD,   0, 1, 0, 0, 0, 0, 4};
        vecs[13] = '{32'h00000463, 1, 0, 0, 3, ALU_SUB,   0, 0, 0, 0, 1, 0, 0};
        vecs[14] = '{32'h00000463, 0, 0, 0, 3, ALU_SUB,   0, 0, 0, 0, 0, 0, 0};
        vecs[15] = '{32'h0020C463, 1, 0, 0, 3, ALU_SLT,   0, 0, 0, 0, 1, 0, 0};
        vecs[16] = '{32'h002081B3, 0, 2, 0, 6, ALU_ADD,   0, 0, 1, 0, 0, 0, 0};

        rst_n            = 1'b0;
        instruction_code = '0;
        branch_taken     = 1'b0;
        mem_ready        = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check_reset_outputs("initial reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            run_instr(vecs[i], o);
            nm = $sformatf("v%0d", i);
            check({nm, " retired"}, o.done, 1'b1);
            check({nm, " cycles"}, o.cycles, vecs[i].cycles);
            check({nm, " alu exec"}, o.alu_exec, vecs[i].alu);
            check({nm, " alu held"}, o.alu_last, vecs[i].alu);
            check({nm, " srcA"}, o.src_a, vecs[i].src_a);
            check({nm, " srcB"}, o.src_b, vecs[i].src_b);
            check({nm, " regwrites"}, o.reg_writes, vecs[i].reg_writes);
            if (vecs[i].reg_writes > 0) check({nm, " memtoreg"}, o.m2r, vecs[i].m2r);
            check({nm, " pcwrites"}, o.pc_writes, 1);
            check({nm, " pcsrc"}, o.pcsrc, vecs[i].pcsrc);
            check({nm, " memread cycles"}, o.mem_rd, vecs[i].mem_rd);
            check({nm, " memwrite cycles"}, o.mem_wr, vecs[i].mem_wr);
            check({nm, " instrread cycles"}, o.instr_rd, vecs[i].fwaits + 1);
            check({nm, " irwrite pulses"}, o.ir_wr, 1);
            check({nm, " request overlap"}, o.excl_viol, 0);
            check({nm, " alu nop early"}, o.early_alu, 0);
            check({nm, " bus_error"}, o.bus_err, 0);
            if (!o.done) apply_reset({nm, " recovery"});
        end

        // Illegal opcode: trap on dut, NOP retire on dut_nt
        instruction_code = 32'h00000000;
        branch_taken     = 1'b0;
        mem_ready        = 1'b1;
        @(negedge clk);
        check("illegal fetch state", state_o, FETCH);
        @(posedge clk); #1;
        @(negedge clk);
        check("illegal decode state", state_o, DECODE);
        check("trap decode pcwrite", PCWrite, 1'b0);
        check("trap decode retire", instr_retired, 1'b0);
        check("nop decode pcwrite", nt_PCWrite, 1'b1);
        check("nop decode pcsrc", nt_PCSrc, 2'd0);
        check("nop decode retire", nt_instr_retired, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        check("trap state", state_o, TRAP);
        check("illegal flag", illegal_instr, 1'b1);
        check("nop next state", nt_state_o, FETCH);
        check("nop next InstrRead", nt_InstrRead, 1'b1);
        strobes = 0;
        repeat (4) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (InstrRead || IRWrite || PCWrite || RegWrite || MemRead || MemWrite || instr_retired)
                strobes++;
        end
        check("trap strobes", strobes, 0);
        check("trap absorbing", state_o, TRAP);
        check("illegal held", illegal_instr, 1'b1);
        check("illegal no bus_error", bus_error, 1'b0);
        apply_reset("reset after trap");

        // Store with mem_ready stuck low in MEM: timeout after 4 MEM cycles
        instruction_code = 32'h0050A223;
        cnt_mw = 0; first_err = 0; cnt_pcw = 0; cnt_ret = 0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            mem_ready = (state_o != MEM);
            @(negedge clk);
            if (MemWrite) cnt_mw++;
            if (bus_error && first_err == 0) first_err = cyc;
            if (PCWrite) cnt_pcw++;
            if (instr_retired) cnt_ret++;
            @(posedge clk); #1;
        end
        check("timeout memwrite cycles", cnt_mw, 4);
        check("timeout bus_error cycle", first_err, 8);
        check("timeout no pcwrite", cnt_pcw, 0);
        check("timeout no retire", cnt_ret, 0);
        check("timeout trap state", state_o, TRAP);
        check("timeout memwrite off", MemWrite, 1'b0);
        check("timeout bus_error held", bus_error, 1'b1);
        check("timeout no illegal", illegal_instr, 1'b0);
        apply_reset("reset after bus error");

        // Load abandoned by reset in the middle of a MEM wait
        instruction_code = 32'h0000A283;
        cnt_rw = 0; cnt_pcw = 0;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            if (cyc > 1) begin
                @(posedge clk); #1;
            end
            mem_ready = (state_o != MEM);
            @(negedge clk);
            if (RegWrite) cnt_rw++;
            if (PCWrite) cnt_pcw++;
        end
        check("midmem state", state_o, MEM);
        check("midmem memread", MemRead, 1'b1);
        apply_reset("reset mid-MEM");
        check("midmem no regwrite", cnt_rw, 0);
        check("midmem no pcwrite", cnt_pcw, 0);

        run_instr(vecs[0], o);
        check("post-reset add cycles", o.cycles, 4);
        check("post-reset add regwrites", o.reg_writes, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 Clocking SHALL be one clock, `clk`; reset SHALL be `rst_n`, synchronous and active-low.
REQ-002 Parameter ALUCTRL_W, default 5: width of ALUControl.
REQ-003 Parameter MAX_WAIT, default 16: memory wait-cycle limit; 0 disables the timeout.
REQ-004 Parameter ENABLE_TRAP, default 1: 1 = illegal opcode enters TRAP; 0 = illegal opcode is retired as a NOP.
REQ-005 Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- instruction_code  in  32  instruction register contents
- branch_taken  in  1  comparator result
- mem_ready  in  1  memory acknowledge
- InstrRead  out  1  instruction fetch request
- IRWrite  out  1  instruction register load strobe
- PCWrite  out  1  PC update strobe
- ALUSrc_A  out  1  0 = rs1, 1 = PC
- ALUSrc_B  out  1  0 = rs2, 1 = immediate
- MemtoReg  out  2  0 = ALU, 1 = memory, 2 = PC+4, 3 = immediate
- RegWrite  out  1  register-file write strobe
- MemRead  out  1  data read request
- MemWrite  out  1  data write request
- Branch  out  1  branch instruction in EXECUTE
- PCSrc  out  2  0 = PC+4, 1 = branch target, 2 = JAL target, 3 = JALR target
- ALUControl  out  ALUCTRL_W  ALU operation, using the shared ALU_* codes
- instr_retired  out  1  one-cycle pulse per completed instruction
- illegal_instr  out  1  sticky illegal-opcode flag
- bus_error  out  1  sticky memory-timeout flag
- state_o  out  3  current state, for debug

Function
REQ-006 The FSM SHALL have six states: FETCH, DECODE, EXECUTE, MEM, WRITEBACK, TRAP. All outputs SHALL be combinational from the state register and instruction_code.
REQ-007 FETCH SHALL:
- assert InstrRead;
- on the mem_ready cycle, pulse IRWrite and go to DECODE.
REQ-008 DECODE SHALL last exactly 1 cycle.
- Legal opcode (R, I-arith, load, S, B, LUI, AUIPC, JAL, JALR): go to EXECUTE.
- Illegal opcode with ENABLE_TRAP=1: go to TRAP.
- Illegal opcode with ENABLE_TRAP=0: assert PCWrite with PCSrc=0, pulse instr_retired, go to FETCH.
REQ-009 EXECUTE SHALL drive ALUControl, ALUSrc_A and ALUSrc_B with the single-cycle RV32I decode, then branch by type:
- B-type: assert Branch and PCWrite, PCSrc = branch_taken ? 1 : 0, pulse instr_retired, go to FETCH (3 cycles total).
- Load or store: go to MEM.
- All others: go to WRITEBACK.
REQ-010 MEM SHALL hold MemRead (load) or MemWrite (store) until mem_ready, then:
- load: go to WRITEBACK;
- store: in the mem_ready cycle assert PCWrite (PCSrc=0), pulse instr_retired, go to FETCH.
REQ-011 WRITEBACK SHALL last 1 cycle, then go to FETCH. In that cycle it SHALL:
- assert RegWrite;
- set MemtoReg: load = 1, JAL/JALR = 2, LUI = 3, else 0;
- assert PCWrite, with PCSrc: JAL = 2, JALR = 3, else 0;
- pulse instr_retired.
REQ-012 ALUControl SHALL hold its EXECUTE value through MEM and WRITEBACK, and SHALL be ALU_NOP in FETCH, DECODE and TRAP.
REQ-013 Latency with mem_ready always high:
- R / I-arith / LUI / AUIPC / JAL / JALR = 4 cycles
- load = 5 cycles
- store = 4 cycles
- branch = 3 cycles
Each memory wait cycle adds exactly 1 cycle.
REQ-014 The wait counter SHALL:
- clear on entry to FETCH or MEM and count each cycle mem_ready is low;
- when MAX_WAIT≠0 and the count reaches MAX_WAIT, set bus_error and go to TRAP, with the request deasserted in the following cycle.
REQ-015 TRAP SHALL be absorbing until reset:
- all strobes 0;
- illegal_instr or bus_error held at 1;
- mem_ready ignored.
REQ-016 mem_ready arriving together with timeout expiry SHALL win: the access completes and bus_error stays 0.
REQ-017 At most one of MemRead, MemWrite and InstrRead SHALL be high in any cycle; PCWrite SHALL be asserted at most once per instruction.

Reset
REQ-018 While rst_n is low at a clk edge, the FSM SHALL load FETCH; the wait counter, illegal_instr and bus_error SHALL clear.
REQ-019 While rst_n is low, all outputs SHALL be 0 and ALUControl SHALL be ALU_NOP.
REQ-020 Reset asserted in any state, including mid-MEM wait, SHALL abandon the instruction with no RegWrite or PCWrite. The first post-reset cycle SHALL be FETCH with InstrRead=1.

Structure
REQ-021 The shared package SHALL hold the state enum, opcode constants and ALU_* codes, reused by the datapath.
REQ-022 The combinational opcode/funct-to-ALUControl decode SHALL be a sub-module, alu_decoder, instantiated once.

Verification
REQ-023 add x3,x1,x2 (0x002081B3), mem_ready=1 -> FETCH, DECODE, EXECUTE, WRITEBACK; RegWrite=1, MemtoReg=0 and PCWrite=1 in cycle 4; ALUControl=ALU_ADD.
REQ-024 lw x5,0(x1) (0x0000A283), mem_ready low for 3 MEM cycles -> MemRead high 4 cycles; WRITEBACK with MemtoReg=1; 8 cycles total.
REQ-025 beq x0,x0,8 (0x00000463), branch_taken=1 -> PCSrc=1 and PCWrite=1 in EXECUTE; instr_retired at cycle 3; RegWrite never high.
REQ-026 Instruction 0x00000000 with ENABLE_TRAP=1 -> TRAP, illegal_instr=1 held. With ENABLE_TRAP=0 -> PC+4 and FETCH.
REQ-027 sw x5,4(x1) (0x0050A223), MAX_WAIT=4, mem_ready stuck low -> bus_error after 4 MEM cycles; MemWrite then 0; rst_n low for 1 cycle restores FETCH.
